ab_parallel_merge: RTL and testbench
====================================

# ab_parallel_merge

Merge stage directly downstream of the two parallel AB policy enforcers (policy a, policy b). Consumes both enforced copies of `A_ctp`/`B_ctp` and produces one registered, conservatively merged output pair. Tracks disagreement between the enforcers and forces a safe lockout after a run of consecutive conflicts. Optional saturating statistics count enforcer edits and conflicts.

## Interface
Parameters:
- `CONFLICT_LIMIT`, 4, consecutive conflict cycles that trigger lockout (legal range ≥1)
- `HOLD_CYCLES`, 8, minimum LOCKOUT dwell before `lockout_clear` is honoured (≥0)
- `STAT_W`, 16, statistics counter width

Ports:
- `clk` in 1: single clock, all state rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `A_ctp`, `B_ctp` in 1 each: raw pre-enforcement inputs
- `A_ctp_enf_a`, `B_ctp_enf_a` in 1 each: policy a enforced outputs
- `A_ctp_enf_b`, `B_ctp_enf_b` in 1 each: policy b enforced outputs
- `lockout_clear` in 1: request to leave LOCKOUT
- `A_ctp_out`, `B_ctp_out` out 1 each: registered merged outputs
- `conflict` out 1: registered, enforcers disagreed last cycle
- `lockout` out 1: state == LOCKOUT
- `merge_state` out 2: current FSM state
- `edit_cnt_a`, `edit_cnt_b`, `conflict_cnt` out `STAT_W` each: statistics

## Operation
- Merge: `m_A = A_ctp_enf_a & A_ctp_enf_b`, `m_B = B_ctp_enf_a & B_ctp_enf_b`.
- Conflict: `c = (A_ctp_enf_a ^ A_ctp_enf_b) | (B_ctp_enf_a ^ B_ctp_enf_b)`.
- FSM states: AGREE=0, CONFLICT=1, LOCKOUT=2. Encoding 3 is illegal and goes to LOCKOUT.
  - AGREE: if `c` then `run_cnt`=1. If `CONFLICT_LIMIT`==1, go to LOCKOUT; otherwise go to CONFLICT.
  - CONFLICT: if `c` and `run_cnt+1 == CONFLICT_LIMIT`, go to LOCKOUT. If `c` otherwise, increment `run_cnt`. If `!c`, go to AGREE with `run_cnt`=0.
  - LOCKOUT: `hold_cnt` is 0 on entry and increments, saturating at `HOLD_CYCLES`. Go to AGREE when `lockout_clear & !c & hold_cnt == HOLD_CYCLES`. `lockout_clear` during a conflict or before the hold expires is ignored, not latched.
- Output register: next value = 0 if next state is LOCKOUT, else (`m_A`, `m_B`).
- `conflict` register: next value = `c` in all states.
- Reset values: all outputs, counters, `run_cnt` and `hold_cnt` are 0; state = AGREE.
- Reset asserted mid-LOCKOUT or mid-run: immediate return to reset values. Run history is not retained.

## Timing
- Inputs are sampled at edge N; `*_out`, `conflict`, `merge_state` and `lockout` reflect them after edge N. Latency is 1 cycle, with no combinational input-to-output path.
- With `CONFLICT_LIMIT`=4, conflicts sampled at edges N..N+3 put LOCKOUT and forced-0 outputs in effect after N+3. A non-conflict at any edge in that run resets the run.
- Entering LOCKOUT at edge E: the earliest honoured clear is sampled at edge E+`HOLD_CYCLES`+1. After that edge, outputs equal the merge of the same-edge inputs.
- Conflict and clear in the same cycle: the conflict wins and the block stays in LOCKOUT.
- Counters saturate at `2^STAT_W-1` and never wrap.

## Configuration
- `AB_MERGE_STATS_EN` defined:
  - `edit_cnt_a` increments when `A_ctp != m_A` or `B_ctp != m_B` under policy a's values, i.e. when policy a edited an input.
  - `edit_cnt_b` increments the same way for policy b.
  - `conflict_cnt` increments on each `c`.
  - All three saturate and reset to 0.
- Undefined: the three ports remain present and are tied to 0. No counter flops are synthesized.

## Structure
- Package `ab_merge_pkg` holds:
  - typedef enum `merge_state_t` (AGREE/CONFLICT/LOCKOUT, 2 bits)
  - default constants `AB_CONFLICT_LIMIT_DEF`, `AB_HOLD_CYCLES_DEF`, `AB_STAT_W_DEF`
- Sub-module `ab_sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `count`): saturating incrementer, instantiated three times under the macro.

## Test plan
- Reset, then both enforcers pass A=1,B=0 → after the next edge `A_ctp_out`=1, `B_ctp_out`=0, `merge_state`=0, `conflict`=0.
- `A_ctp_enf_a`=1, `A_ctp_enf_b`=0 for 3 cycles, then agree → `conflict` high for 3 cycles, state goes 1,1,1,0, no lockout, `A_ctp_out`=0 throughout.
- Conflict for 4 cycles (LIMIT=4) → `lockout`=1 after the 4th edge and outputs 0. `lockout_clear` at hold_cnt=5 is ignored. Clear with no conflict after 8 hold cycles → AGREE and outputs follow the merge next cycle.
- In LOCKOUT with hold expired, assert clear while the enforcers disagree → stays LOCKOUT. Drop the conflict the next cycle while clear stays high → AGREE.
- Assert `rst_n`=0 asynchronously mid-LOCKOUT → all outputs 0 and state AGREE without waiting for a clock edge.
- With `AB_MERGE_STATS_EN`, STAT_W=4, raw A=1 and policy a forcing A=0 for 20 cycles → `edit_cnt_a` reaches 15 and holds; `edit_cnt_b`=0.

Source files
------------

// File: rtl/ab_merge_pkg.sv
// Shared types and default constants for the AB parallel merge stage.
package ab_merge_pkg;

    typedef enum logic [1:0] {
        AGREE    = 2'd0,
        CONFLICT = 2'd1,
        LOCKOUT  = 2'd2
    } merge_state_t;

    localparam int AB_CONFLICT_LIMIT_DEF = 4;
    localparam int AB_HOLD_CYCLES_DEF    = 8;
    localparam int AB_STAT_W_DEF         = 16;

endpackage

// File: rtl/ab_parallel_merge_if.sv
// Bundle of enforcer inputs and merged outputs for ab_parallel_merge.
interface ab_parallel_merge_if
    import ab_merge_pkg::*;
#(
    parameter int STAT_W = AB_STAT_W_DEF
);
    logic              A_ctp, B_ctp;
    logic              A_ctp_enf_a, B_ctp_enf_a;
    logic              A_ctp_enf_b, B_ctp_enf_b;
    logic              lockout_clear;
    logic              A_ctp_out, B_ctp_out;
    logic              conflict;
    logic              lockout;
    logic [1:0]        merge_state;
    logic [STAT_W-1:0] edit_cnt_a, edit_cnt_b, conflict_cnt;

    modport master (
        output A_ctp, B_ctp, A_ctp_enf_a, B_ctp_enf_a, A_ctp_enf_b, B_ctp_enf_b, lockout_clear,
        input  A_ctp_out, B_ctp_out, conflict, lockout, merge_state,
               edit_cnt_a, edit_cnt_b, conflict_cnt
    );

    modport slave (
        input  A_ctp, B_ctp, A_ctp_enf_a, B_ctp_enf_a, A_ctp_enf_b, B_ctp_enf_b, lockout_clear,
        output A_ctp_out, B_ctp_out, conflict, lockout, merge_state,
               edit_cnt_a, edit_cnt_b, conflict_cnt
    );
endinterface

// File: rtl/ab_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module ab_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count_q <= '0;
        else if (inc && count_q != '1) count_q <= count_q + W'(1);
    end

    assign count = count_q;
endmodule

// File: rtl/ab_parallel_merge.sv
// Conservative AND-merge of two AB enforcers with conflict-run lockout.
// Define AB_MERGE_STATS_EN to build the edit/conflict statistics counters.
module ab_parallel_merge
    import ab_merge_pkg::*;
#(
    parameter int CONFLICT_LIMIT = AB_CONFLICT_LIMIT_DEF,
    parameter int HOLD_CYCLES    = AB_HOLD_CYCLES_DEF,
    parameter int STAT_W         = AB_STAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    ab_parallel_merge_if.slave  mrg_if
);
    localparam int RUN_W  = (CONFLICT_LIMIT > 1) ? $clog2(CONFLICT_LIMIT + 1) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(CONFLICT_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic m_a, m_b, c;
    merge_state_t      state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              a_out_q, a_out_d, b_out_q, b_out_d, conf_q;

    assign m_a = mrg_if.A_ctp_enf_a & mrg_if.A_ctp_enf_b;
    assign m_b = mrg_if.B_ctp_enf_a & mrg_if.B_ctp_enf_b;
    assign c   = (mrg_if.A_ctp_enf_a ^ mrg_if.A_ctp_enf_b) |
                 (mrg_if.B_ctp_enf_a ^ mrg_if.B_ctp_enf_b);

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        hold_cnt_d = '0;
        case (state_q)
            AGREE: begin
                run_cnt_d = '0;
                if (c) begin
                    run_cnt_d = RUN_W'(1);
                    state_d   = (CONFLICT_LIMIT == 1) ? LOCKOUT : CONFLICT;
                end
            end
            CONFLICT: begin
                if (!c) begin
                    state_d   = AGREE;
                    run_cnt_d = '0;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d   = LOCKOUT;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            LOCKOUT: begin
                run_cnt_d = '0;
                // A clear that arrives early or alongside a conflict is dropped, not remembered.
                if (mrg_if.lockout_clear && !c && hold_cnt_q == HOLD_MAX)
                    state_d = AGREE;
                else
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
            end
            default: begin
                state_d   = LOCKOUT;
                run_cnt_d = '0;
            end
        endcase
        a_out_d = (state_d == LOCKOUT) ? 1'b0 : m_a;
        b_out_d = (state_d == LOCKOUT) ? 1'b0 : m_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AGREE;
            run_cnt_q  <= '0;
            hold_cnt_q <= '0;
            a_out_q    <= 1'b0;
            b_out_q    <= 1'b0;
            conf_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            conf_q     <= c;
        end
    end

    assign mrg_if.A_ctp_out   = a_out_q;
    assign mrg_if.B_ctp_out   = b_out_q;
    assign mrg_if.conflict    = conf_q;
    assign mrg_if.lockout     = (state_q == LOCKOUT);
    assign mrg_if.merge_state = state_q;

`ifdef AB_MERGE_STATS_EN
    logic edit_a, edit_b;
    // An edit is any difference between the raw pair and that policy's enforced pair.
    assign edit_a = (mrg_if.A_ctp != mrg_if.A_ctp_enf_a) | (mrg_if.B_ctp != mrg_if.B_ctp_enf_a);
    assign edit_b = (mrg_if.A_ctp != mrg_if.A_ctp_enf_b) | (mrg_if.B_ctp != mrg_if.B_ctp_enf_b);

    ab_sat_counter #(.W(STAT_W)) u_edit_a (
        .clk(clk), .rst_n(rst_n), .inc(edit_a), .count(mrg_if.edit_cnt_a));
    ab_sat_counter #(.W(STAT_W)) u_edit_b (
        .clk(clk), .rst_n(rst_n), .inc(edit_b), .count(mrg_if.edit_cnt_b));
    ab_sat_counter #(.W(STAT_W)) u_conf (
        .clk(clk), .rst_n(rst_n), .inc(c), .count(mrg_if.conflict_cnt));
`else
    logic unused_raw;
    assign unused_raw          = mrg_if.A_ctp ^ mrg_if.B_ctp;
    assign mrg_if.edit_cnt_a   = '0;
    assign mrg_if.edit_cnt_b   = '0;
    assign mrg_if.conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_ab_parallel_merge.sv
// Self-checking bench for ab_parallel_merge: directed table, lockout sequences, random vs model.
module tb_ab_parallel_merge;
    import ab_merge_pkg::*;

    localparam int LIMIT = 4;
    localparam int HOLD  = 8;
    localparam int SW    = 4;
    localparam int SMAX  = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ab_parallel_merge_if #(.STAT_W(SW)) bus ();

    ab_parallel_merge #(.CONFLICT_LIMIT(LIMIT), .HOLD_CYCLES(HOLD), .STAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .mrg_if(bus));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: conflict run length, lockout flag, edges since lockout entry.
    int m_run, m_since, m_ea, m_eb, m_cc;
    bit m_lock, m_oa, m_ob, m_conf;

    typedef struct packed {
        bit aa, ab, ba, bb, clr;
        bit e_a, e_b, e_conf;
        logic [1:0] e_st;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int stat_exp(input int v);
`ifdef AB_MERGE_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_since = 0; m_lock = 0;
        m_oa = 0; m_ob = 0; m_conf = 0;
        m_ea = 0; m_eb = 0; m_cc = 0;
    endtask

    task automatic model_edge();
        bit c, ea, eb;
        c  = (bus.A_ctp_enf_a ^ bus.A_ctp_enf_b) | (bus.B_ctp_enf_a ^ bus.B_ctp_enf_b);
        ea = (bus.A_ctp != bus.A_ctp_enf_a) || (bus.B_ctp != bus.B_ctp_enf_a);
        eb = (bus.A_ctp != bus.A_ctp_enf_b) || (bus.B_ctp != bus.B_ctp_enf_b);
        if (m_lock) begin
            if (bus.lockout_clear && !c && m_since >= HOLD) m_lock = 0;
            else m_since++;
        end else if (c) begin
            m_run++;
            if (m_run >= LIMIT) begin m_lock = 1; m_since = 0; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_oa   = m_lock ? 1'b0 : (bus.A_ctp_enf_a & bus.A_ctp_enf_b);
        m_ob   = m_lock ? 1'b0 : (bus.B_ctp_enf_a & bus.B_ctp_enf_b);
        m_conf = c;
        if (ea && m_ea < SMAX) m_ea++;
        if (eb && m_eb < SMAX) m_eb++;
        if (c  && m_cc < SMAX) m_cc++;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".A_out"},   bus.A_ctp_out, m_oa);
        chk({tag, ".B_out"},   bus.B_ctp_out, m_ob);
        chk({tag, ".conflict"}, bus.conflict, m_conf);
        chk({tag, ".state"},   bus.merge_state, m_lock ? 2 : (m_run > 0 ? 1 : 0));
        chk({tag, ".lockout"}, bus.lockout, m_lock);
        chk({tag, ".edit_a"},  bus.edit_cnt_a, stat_exp(m_ea));
        chk({tag, ".edit_b"},  bus.edit_cnt_b, stat_exp(m_eb));
        chk({tag, ".conf_cnt"}, bus.conflict_cnt, stat_exp(m_cc));
    endtask

    task automatic drive(input bit ra, rb, aa, ab, ba, bb, clr);
        bus.A_ctp = ra; bus.B_ctp = rb;
        bus.A_ctp_enf_a = aa; bus.B_ctp_enf_a = ab;
        bus.A_ctp_enf_b = ba; bus.B_ctp_enf_b = bb;
        bus.lockout_clear = clr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".A_out"}, bus.A_ctp_out, 0);
        chk({tag, ".B_out"}, bus.B_ctp_out, 0);
        chk({tag, ".conflict"}, bus.conflict, 0);
        chk({tag, ".state"}, bus.merge_state, 0);
        chk({tag, ".lockout"}, bus.lockout, 0);
        chk({tag, ".edit_a"}, bus.edit_cnt_a, 0);
        chk({tag, ".conf_cnt"}, bus.conflict_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pc;
        //           aa ab ba bb clr  eA eB eC st
        tbl[0] = '{1, 0, 1, 0, 0,  1, 0, 0, 2'd0};
        tbl[1] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[2] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[3] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[4] = '{1, 0, 1, 0, 0,  1, 0, 0, 2'd0};
        tbl[5] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[6] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[7] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd1};
        tbl[8] = '{1, 0, 0, 0, 0,  0, 0, 1, 2'd2};

        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].aa, tbl[i].ab, tbl[i].aa, tbl[i].ab, tbl[i].ba, tbl[i].bb, tbl[i].clr);
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.A_out", i), bus.A_ctp_out, tbl[i].e_a);
            chk($sformatf("tbl%0d.B_out", i), bus.B_ctp_out, tbl[i].e_b);
            chk($sformatf("tbl%0d.conflict", i), bus.conflict, tbl[i].e_conf);
            chk($sformatf("tbl%0d.state", i), bus.merge_state, tbl[i].e_st);
        end

        // Lockout entered at the last table edge; probe early clears then the first legal one.
        for (int k = 1; k <= 9; k++) begin
            drive(1, 1, 1, 1, 1, 1, (k == 6 || k == 8 || k == 9));
            step($sformatf("hold%0d", k));
            if (k < 9) chk($sformatf("hold%0d.lockout", k), bus.lockout, 1);
        end
        chk("clear.state", bus.merge_state, 0);
        chk("clear.A_out", bus.A_ctp_out, 1);
        chk("clear.B_out", bus.B_ctp_out, 1);

        // Clear during a conflict loses; clear one cycle later wins.
        for (int k = 0; k < LIMIT; k++) begin drive(0, 1, 0, 1, 0, 0, 0); step("run2"); end
        chk("run2.lockout", bus.lockout, 1);
        for (int k = 0; k < HOLD; k++) begin drive(0, 0, 0, 0, 0, 0, 0); step("idle2"); end
        drive(0, 1, 0, 1, 0, 0, 1); step("clrconf");
        chk("clrconf.lockout", bus.lockout, 1);
        drive(0, 1, 0, 1, 0, 1, 1); step("clrok");
        chk("clrok.state", bus.merge_state, 0);
        chk("clrok.B_out", bus.B_ctp_out, 1);

        // Asynchronous reset in the middle of LOCKOUT.
        for (int k = 0; k < LIMIT; k++) begin drive(1, 0, 1, 0, 0, 0, 0); step("run3"); end
        for (int k = 0; k < 3; k++) begin drive(1, 1, 1, 1, 1, 1, 0); step("idle3"); end
        chk("run3.lockout", bus.lockout, 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Policy a keeps editing A for 20 cycles; counters must saturate.
        for (int k = 0; k < 20; k++) begin drive(1, 0, 0, 0, 1, 0, 0); step("stats"); end
        chk("stats.edit_a_sat", bus.edit_cnt_a, stat_exp(SMAX));
        chk("stats.edit_b_zero", bus.edit_cnt_b, 0);
        chk("stats.conf_sat", bus.conflict_cnt, stat_exp(SMAX));
        do_reset();

        // Random traffic with alternating calm and conflict-heavy phases.
        for (int k = 0; k < 600; k++) begin
            bit aa, ab, ba, bb;
            pc = ((k / 50) % 2 == 0) ? 10 : 75;
            aa = 1'($urandom_range(0, 1));
            ab = 1'($urandom_range(0, 1));
            ba = aa; bb = ab;
            if ($urandom_range(0, 99) < pc) begin
                if ($urandom_range(0, 1) == 1) ba = ~aa; else bb = ~ab;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, ab, ba, bb,
                  ($urandom_range(0, 2) == 0));
            step($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
